// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-seven-segment lookup for the multiplexed display peripheral.
package seg_pkg;

    localparam logic [1:0] ADDR_SW0  = 2'd0;
    localparam logic [1:0] ADDR_SW1  = 2'd1;
    localparam logic [1:0] ADDR_DATA = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int EN_BIT    = 0;
    localparam int BLANK_LSB = 8;
    localparam int DP_LSB    = 16;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Segments ordered a..g from bit 6 down to bit 0, active low.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'b0000001;
            4'h1:    hex7 = 7'b1001111;
            4'h2:    hex7 = 7'b0010010;
            4'h3:    hex7 = 7'b0000110;
            4'h4:    hex7 = 7'b1001100;
            4'h5:    hex7 = 7'b0100100;
            4'h6:    hex7 = 7'b0100000;
            4'h7:    hex7 = 7'b0001101;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0000100;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b1100000;
            4'hC:    hex7 = 7'b0110001;
            4'hD:    hex7 = 7'b1000010;
            4'hE:    hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

endpackage

// File: rtl/seg_display_ctrl_scan.sv
// Refresh divider and digit index for the display scan; runs independently of the enable bit.
module seg_scan #(
    parameter int unsigned REFRESH_DIV = 200000,
    parameter int unsigned NUM_DIGITS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [2:0]            idx,
    output logic [NUM_DIGITS-1:0] sel
);

    localparam int unsigned      CNT_W  = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       LAST   = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= RELOAD;
            idx <= 3'd0;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
            idx <= (idx == LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign sel = NUM_DIGITS'(1) << idx;

endmodule

// File: rtl/seg_display_ctrl.sv
// Bus-mapped 7-segment display driver with two synchronised 32-bit switch banks.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned REFRESH_DIV = 200000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    input  logic [31:0]           sw0,
    input  logic [31:0]           sw1,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] sel
);

    // Mask bits for digits that do not exist are never stored.
    localparam logic [7:0] DIG_MASK = 8'((16'd1 << NUM_DIGITS) - 16'd1);

    logic [31:0]     data_q;
    logic            en_q;
    logic [7:0]      blank_q;
    logic [7:0]      dp_q;
    logic [31:0]     sw0_meta, sw0_sync;
    logic [31:0]     sw1_meta, sw1_sync;
    logic [2:0]      idx;
    logic [7:0][3:0] nib;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            en_q     <= 1'b1;
            blank_q  <= '0;
            dp_q     <= '0;
            sw0_meta <= '0;
            sw0_sync <= '0;
            sw1_meta <= '0;
            sw1_sync <= '0;
        end else begin
            sw0_meta <= sw0;
            sw0_sync <= sw0_meta;
            sw1_meta <= sw1;
            sw1_sync <= sw1_meta;
            if (we && addr == ADDR_DATA) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) data_q[8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            if (we && addr == ADDR_CTRL) begin
                if (be[0]) en_q    <= wdata[EN_BIT];
                if (be[1]) blank_q <= wdata[BLANK_LSB +: 8] & DIG_MASK;
                if (be[2]) dp_q    <= wdata[DP_LSB +: 8] & DIG_MASK;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_SW0:  rdata = sw0_sync;
            ADDR_SW1:  rdata = sw1_sync;
            ADDR_DATA: rdata = data_q;
            default:   rdata = {8'h00, dp_q, blank_q, 7'h00, en_q};
        endcase
    end

    seg_scan #(
        .REFRESH_DIV (REFRESH_DIV),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .idx   (idx),
        .sel   (sel)
    );

    assign nib = data_q;

    // Decode depends only on registered state, never on the bus inputs.
    always_comb begin
        seg = SEG_OFF;
        if (en_q && !blank_q[idx]) seg = {~dp_q[idx], hex7(nib[idx])};
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: vector table, directed corner sequences and randomized traffic against a cycle-count model.
module tb_seg_display_ctrl;

    localparam int ND = 8;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [3:0]  be = 4'h0;
    logic [31:0] wdata = '0;
    logic [31:0] sw0 = '0;
    logic [31:0] sw1 = '0;
    logic [31:0] rdata, rdata4;
    logic [7:0]  seg, seg4;
    logic [7:0]  sel;
    logic [3:0]  sel4;

    always #5 clk = ~clk;

    seg_display_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .be(be), .wdata(wdata),
        .rdata(rdata), .sw0(sw0), .sw1(sw1), .seg(seg), .sel(sel)
    );

    seg_display_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(RD)) dut4 (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .be(be), .wdata(wdata),
        .rdata(rdata4), .sw0(sw0), .sw1(sw1), .seg(seg4), .sel(sel4)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] HEX [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Model: register contents plus the number of edges since reset released.
    logic [31:0] m_data = '0, m_sw0_a = '0, m_sw0_b = '0, m_sw1_a = '0, m_sw1_b = '0;
    logic        m_en = 1'b1;
    logic [7:0]  m_blank = '0, m_dp = '0;
    int          m_cyc = 0;

    function automatic int m_idx(input int n);
        return (m_cyc / RD) % n;
    endfunction

    function automatic logic [7:0] m_seg(input int n);
        int i;
        i = m_idx(n);
        if (!m_en || m_blank[i]) return 8'hFF;
        return {~m_dp[i], HEX[m_data[4*i +: 4]]};
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a, input int n);
        logic [7:0] mk;
        mk = (n == 8) ? 8'hFF : 8'h0F;
        case (a)
            2'd0:    return m_sw0_b;
            2'd1:    return m_sw1_b;
            2'd2:    return m_data;
            default: return {8'h00, m_dp & mk, m_blank & mk, 7'h00, m_en};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_data = '0; m_en = 1'b1; m_blank = '0; m_dp = '0;
            m_sw0_a = '0; m_sw0_b = '0; m_sw1_a = '0; m_sw1_b = '0;
            m_cyc = 0;
        end else begin
            if (we && addr == 2'd2)
                for (int b = 0; b < 4; b++) if (be[b]) m_data[8*b +: 8] = wdata[8*b +: 8];
            if (we && addr == 2'd3) begin
                if (be[0]) m_en = wdata[0];
                if (be[1]) m_blank = wdata[15:8];
                if (be[2]) m_dp = wdata[23:16];
            end
            m_sw0_b = m_sw0_a; m_sw0_a = sw0;
            m_sw1_b = m_sw1_a; m_sw1_a = sw1;
            m_cyc++;
        end
        #1;
        check("sel", {24'h0, sel}, 32'(1 << m_idx(8)));
        check("seg", {24'h0, seg}, {24'h0, m_seg(8)});
        check("sel4", {28'h0, sel4}, 32'(1 << m_idx(4)));
        check("seg4", {24'h0, seg4}, {24'h0, m_seg(4)});
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
        addr = a; be = b; wdata = d; we = 1'b1;
        tick();
        we = 1'b0; be = 4'h0;
    endtask

    task automatic wait_idx(input int target, input int n);
        int k;
        k = 0;
        while (m_idx(n) != target && k < 64) begin
            tick();
            k++;
        end
        if (m_idx(n) != target) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idx: index %0d not reached, at %0d", target, m_idx(n));
        end
    endtask

    typedef struct {
        logic [1:0]  a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{2'd2, 4'b1111, 32'h89AB_CDEF, 32'h89AB_CDEF};
        vt[1] = '{2'd2, 4'b0100, 32'h0000_0000, 32'h8900_CDEF};
        vt[2] = '{2'd2, 4'b0000, 32'hFFFF_FFFF, 32'h8900_CDEF};
        vt[3] = '{2'd2, 4'b0010, 32'h0000_5500, 32'h8900_55EF};
        vt[4] = '{2'd2, 4'b0010, 32'h0000_CD00, 32'h8900_CDEF};
        vt[5] = '{2'd0, 4'b1111, 32'h0000_1234, 32'h0000_0000};
        vt[6] = '{2'd1, 4'b1111, 32'h0000_1234, 32'h0000_0000};
        vt[7] = '{2'd3, 4'b0001, 32'h0000_0000, 32'h0000_0000};
        vt[8] = '{2'd3, 4'b0110, 32'h0002_0201, 32'h0002_0200};
        vt[9] = '{2'd3, 4'b1001, 32'hFFFF_FF01, 32'h0002_0201};

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_sel", {24'h0, sel}, 32'h01);
        check("rst_seg", {24'h0, seg}, 32'h81);
        read_check("rst_ctrl", 2'd3, 32'h1);
        read_check("rst_sw0", 2'd0, 32'h0);
        read_check("rst_data", 2'd2, 32'h0);

        repeat (3) tick();
        check("sel_edge3", {24'h0, sel}, 32'h01);
        tick();
        check("sel_edge4", {24'h0, sel}, 32'h02);
        repeat (28) tick();
        check("sel_edge32", {24'h0, sel}, 32'h01);

        for (int i = 0; i < 10; i++) begin
            bus_write(vt[i].a, vt[i].be, vt[i].wd);
            read_check($sformatf("vec%0d", i), vt[i].a, vt[i].exp);
        end

        wait_idx(0, 8);
        check("dig0_F", {24'h0, seg}, 32'hB8);
        wait_idx(1, 8);
        check("dig1_blank", {24'h0, seg}, 32'hFF);
        wait_idx(2, 8);
        check("dig2_D", {24'h0, seg}, 32'hC2);

        bus_write(2'd3, 4'hF, 32'h0);
        for (int i = 0; i < ND * RD; i++) begin
            tick();
            check("dis_seg", {24'h0, seg}, 32'hFF);
        end
        bus_write(2'd3, 4'hF, 32'h1);

        sw0 = 32'hDEAD_BEEF;
        tick();
        read_check("sw0_edge1", 2'd0, 32'h0);
        tick();
        read_check("sw0_edge2", 2'd0, 32'hDEAD_BEEF);
        bus_write(2'd0, 4'hF, 32'h1234);
        read_check("sw0_ro", 2'd0, 32'hDEAD_BEEF);

        bus_write(2'd3, 4'hF, 32'hFFFF_FFFF);
        addr = 2'd3;
        #1;
        check("ctrl4_mask", rdata4, 32'h000F_0F01);
        check("ctrl8_mask", rdata, 32'h00FF_FF01);
        bus_write(2'd3, 4'hF, 32'h1);
        wait_idx(3, 4);
        check("sel4_last", {28'h0, sel4}, 32'h8);
        repeat (RD) tick();
        check("sel4_wrap", {28'h0, sel4}, 32'h1);

        wait_idx(5, 8);
        addr = 2'd2; be = 4'hF; wdata = 32'hFFFF_FFFF; we = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; we = 1'b0; be = 4'h0;
        check("mid_rst_sel", {24'h0, sel}, 32'h01);
        read_check("mid_rst_data", 2'd2, 32'h0);
        repeat (3) tick();
        check("mid_rst_hold", {24'h0, sel}, 32'h01);
        tick();
        check("mid_rst_adv", {24'h0, sel}, 32'h02);

        for (int i = 0; i < 600; i++) begin
            logic [1:0] ra;
            we    = 1'($urandom_range(0, 1));
            addr  = 2'($urandom_range(0, 3));
            be    = 4'($urandom_range(0, 15));
            wdata = $urandom;
            if ($urandom_range(0, 3) == 0) sw0 = $urandom;
            if ($urandom_range(0, 3) == 0) sw1 = $urandom;
            reset = ($urandom_range(0, 99) == 0);
            tick();
            reset = 1'b0;
            ra = 2'($urandom_range(0, 3));
            addr = ra;
            #1;
            check("rnd_rd", rdata, m_read(ra, 8));
            check("rnd_rd4", rdata4, m_read(ra, 4));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
